// File: rtl/tanh_pwl_pipe.sv
// Three-stage piecewise-linear tanh for signed fixed point (value = x / SCALE), valid/ready on both
// sides. Define TANH_PWL_STATS_EN to add the saturation counter (stat_clr / sat_count).
module tanh_pwl_pipe #(
  parameter int     WIDTH = 32,
  parameter longint SCALE = 100000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
`ifdef TANH_PWL_STATS_EN
  output logic             out_sat,
  input  logic             stat_clr,
  output logic [15:0]      sat_count
`else
  output logic             out_sat
`endif
);

  localparam longint BP0  = SCALE / 2;
  localparam longint BP1  = SCALE * 12 / 10;
  localparam longint BP2  = SCALE * 24 / 10;
  localparam longint OFF1 = SCALE / 4;
  localparam longint OFF2 = SCALE * 7 / 10;
  localparam longint MAXV = (longint'(1) <<< (WIDTH - 1)) - 1;
  localparam longint MINV = -MAXV - 1;

  localparam logic [WIDTH-1:0] Bp0W   = WIDTH'(BP0);
  localparam logic [WIDTH-1:0] Bp1W   = WIDTH'(BP1);
  localparam logic [WIDTH-1:0] Bp2W   = WIDTH'(BP2);
  localparam logic [WIDTH-1:0] Off1W  = WIDTH'(OFF1);
  localparam logic [WIDTH-1:0] Off2W  = WIDTH'(OFF2);
  localparam logic [WIDTH-1:0] MaxvW  = WIDTH'(MAXV);
  localparam logic [WIDTH-1:0] MinvW  = WIDTH'(MINV);
  localparam logic [WIDTH-1:0] ScaleW = WIDTH'(SCALE);

  localparam logic [1:0] RegR0 = 2'd0;
  localparam logic [1:0] RegR1 = 2'd1;
  localparam logic [1:0] RegR2 = 2'd2;
  localparam logic [1:0] RegRs = 2'd3;

  if (BP2 > MAXV) begin : g_bad_scale
    $error("tanh_pwl_pipe: BP2 = SCALE*24/10 does not fit in WIDTH");
  end

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Stage 1: saturating magnitude and region classification
  logic [WIDTH-1:0] z;
  logic [1:0]       region;

  always_comb begin
    z = '0;
    if (in_x == MinvW) begin
      z = MaxvW;
    end else if (in_x[WIDTH-1]) begin
      z = -in_x;
    end else begin
      z = in_x;
    end
    region = RegRs;
    if (z <= Bp0W) begin
      region = RegR0;
    end else if (z <= Bp1W) begin
      region = RegR1;
    end else if (z <= Bp2W) begin
      region = RegR2;
    end
  end

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_x_q;
  logic             s1_mode_q;
  logic [1:0]       s1_region_q;
  logic             s1_neg;
  assign s1_neg = s1_x_q[WIDTH-1];

  // Stage 2: region term; biasing negatives before the arithmetic shift truncates toward zero
  logic signed [WIDTH-1:0] half_sum, eighth_sum, half_t, eighth_t;
  logic [WIDTH-1:0]        t_d, off_d;
  logic                    sat_d;

  always_comb begin
    half_sum   = $signed(s1_x_q) + $signed({{(WIDTH-1){1'b0}}, s1_neg});
    eighth_sum = $signed(s1_x_q) + $signed({{(WIDTH-3){1'b0}}, {3{s1_neg}}});
    half_t     = half_sum >>> 1;
    eighth_t   = eighth_sum >>> 3;
    t_d        = s1_x_q;
    off_d      = '0;
    sat_d      = 1'b0;
    case (s1_region_q)
      RegR1: begin
        t_d   = half_t;
        off_d = Off1W;
      end
      RegR2: begin
        t_d   = eighth_t;
        off_d = Off2W;
      end
      RegRs: begin
        sat_d = 1'b1;
        if (s1_mode_q) begin
          t_d = s1_neg ? -ScaleW : ScaleW;
        end else begin
          t_d = s1_neg ? MinvW : MaxvW;
        end
      end
      default: t_d = s1_x_q;
    endcase
  end

  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_t_q;
  logic [WIDTH-1:0] s2_off_q;
  logic             s2_neg_q;
  logic             s2_sat_q;

  // Stage 3: apply the signed offset; saturation constants pass through untouched
  logic [WIDTH-1:0] y_d;
  always_comb begin
    y_d = s2_t_q;
    if (!s2_sat_q) begin
      y_d = s2_neg_q ? (s2_t_q - s2_off_q) : (s2_t_q + s2_off_q);
    end
  end

  logic             s3_valid_q;
  logic [WIDTH-1:0] s3_y_q;
  logic             s3_sat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      s3_y_q     <= '0;
      s3_sat_q   <= 1'b0;
    end else if (en) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_x_q      <= in_x;
        s1_mode_q   <= in_mode;
        s1_region_q <= region;
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_t_q   <= t_d;
        s2_off_q <= off_d;
        s2_neg_q <= s1_neg;
        s2_sat_q <= sat_d;
      end
      s3_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        s3_y_q   <= y_d;
        s3_sat_q <= s2_sat_q;
      end
    end
  end

  assign out_valid = s3_valid_q;
  assign out_y     = s3_y_q;
  assign out_sat   = s3_sat_q;

`ifdef TANH_PWL_STATS_EN
  logic [15:0] sat_count_q;
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      sat_count_q <= '0;
    end else if (out_valid && out_ready && out_sat && (sat_count_q != 16'hFFFF)) begin
      sat_count_q <= sat_count_q + 16'd1;
    end
  end
  assign sat_count = sat_count_q;
`endif

endmodule

// File: tb/tb_tanh_pwl_pipe.sv
// Randomised and directed bench for tanh_pwl_pipe, scored against a plain-arithmetic model.
module tb_tanh_pwl_pipe;

  localparam int     W     = 32;
  localparam longint SCALE = 100000000;
  localparam longint BP0   = SCALE / 2;
  localparam longint BP1   = SCALE * 12 / 10;
  localparam longint BP2   = SCALE * 24 / 10;
  localparam longint OFF1  = SCALE / 4;
  localparam longint OFF2  = SCALE * 7 / 10;
  localparam longint MAXV  = 64'sd2147483647;
  localparam longint MINV  = -64'sd2147483648;

  logic         clk       = 1'b0;
  logic         rst       = 1'b1;
  logic         in_valid  = 1'b0;
  logic         in_mode   = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] in_x      = '0;
  logic         in_ready;
  logic         out_valid;
  logic         out_sat;
  logic [W-1:0] out_y;
`ifdef TANH_PWL_STATS_EN
  logic         stat_clr  = 1'b0;
  logic [15:0]  sat_count;
`endif

  tanh_pwl_pipe #(.WIDTH(W), .SCALE(SCALE)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
`ifdef TANH_PWL_STATS_EN
    .out_sat   (out_sat),
    .stat_clr  (stat_clr),
    .sat_count (sat_count)
`else
    .out_sat   (out_sat)
`endif
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  int     cyc    = 0;
  int     n_out  = 0;
  bit     lat_en = 1'b0;
  bit     done   = 1'b0;
  longint exp_y[$];
  bit     exp_sat[$];
  int     acc_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint obs, input longint exp_v);
    checks++;
    if (obs != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // Reference: tanh approximated from |x| with first-match breakpoints, C-style division.
  function automatic void model(input longint x, input bit mode, output longint y,
                                output bit sat);
    longint z;
    z   = (x < 0) ? -x : x;
    if (z > MAXV) z = MAXV;
    sat = 1'b0;
    if (z <= BP0)      y = x;
    else if (z <= BP1) y = x / 2 + ((x < 0) ? -OFF1 : OFF1);
    else if (z <= BP2) y = x / 8 + ((x < 0) ? -OFF2 : OFF2);
    else begin
      sat = 1'b1;
      if (mode) y = (x < 0) ? -SCALE : SCALE;
      else      y = (x < 0) ? MINV : MAXV;
    end
  endfunction

  always @(negedge clk) begin
    longint y;
    bit     s;
    int     lat;
    if (rst) begin
      exp_y.delete();
      exp_sat.delete();
      acc_cyc.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_y.size() == 0) begin
          check("unexpected_out", exp_y.size(), 1);
        end else begin
          check("y", $signed(out_y), exp_y.pop_front());
          check("sat", out_sat, exp_sat.pop_front());
          lat = cyc - acc_cyc.pop_front();
          if (lat_en) check("latency", lat, 3);
        end
      end
      if (in_valid && in_ready) begin
        model($signed(in_x), in_mode, y, s);
        exp_y.push_back(y);
        exp_sat.push_back(s);
        acc_cyc.push_back(cyc);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input longint x, input bit mode);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_x     = x[W-1:0];
    in_mode  = mode;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("send_timeout", n, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_y.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n >= 300) check("drain_timeout", exp_y.size(), 0);
  endtask

  function automatic longint rand_x();
    longint      z;
    int unsigned k;
    k = $urandom_range(0, 6);
    case (k)
      0: return longint'($signed($urandom()));
      1: z = longint'($urandom_range(0, 32'(BP0)));
      2: z = BP0 + 1 + longint'($urandom_range(0, 32'(BP1 - BP0 - 1)));
      3: z = BP1 + 1 + longint'($urandom_range(0, 32'(BP2 - BP1 - 1)));
      4: begin
        case ($urandom_range(0, 3))
          0:       z = BP0;
          1:       z = BP1;
          2:       z = BP2;
          default: z = BP2 + 1;
        endcase
      end
      5: z = BP2 + 1 + longint'($urandom_range(0, 32'(MAXV - BP2 - 1)));
      default: return MINV;
    endcase
    return ($urandom_range(0, 1) != 0) ? -z : z;
  endfunction

  longint core_x[6] = '{30000000, 50000000, -100000000, 120000000, 240000000, -200000000};
  longint tie_x[6]  = '{-50000000, -120000000, -240000000, 50000001, -50000001, 0};
  longint x;
  int     n0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_y", out_y, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Regions, ties, saturation and truncation, all at full rate
    lat_en = 1'b1;
    foreach (core_x[i]) send(core_x[i], 1'b0);
    foreach (tie_x[i]) send(tie_x[i], $urandom_range(0, 1));
    send(240000001, 1'b0);
    send(240000001, 1'b1);
    send(MINV, 1'b0);
    send(MINV, 1'b1);
    send(-40000001, 1'b0);
    send(-100000001, 1'b0);
    drain();
    lat_en = 1'b0;

    // Backpressure: stall 4 cycles from the first out_valid
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 6; i++) send(core_x[i], 1'b1);
      end
      begin
        int n;
        n = 0;
        @(posedge clk);
        #1;
        while (!out_valid && n < 50) begin
          @(posedge clk);
          #1;
          n++;
        end
        check("bp_first_valid", out_valid, 1);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check("bp_in_ready", in_ready, 0);
          check("bp_out_valid", out_valid, 1);
          if (exp_y.size() != 0) check("bp_hold_y", $signed(out_y), exp_y[0]);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", n_out - n0, 6);

    // Reset with three beats in flight; none may be emitted
    out_ready = 1'b0;
    n0 = n_out;
    send(10000000, 1'b0);
    send(-300000000, 1'b0);
    send(150000000, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("midrst_out_valid", out_valid, 0);
    end
    check("midrst_count", n_out - n0, 0);
    @(posedge clk);
    #1;
    lat_en = 1'b1;
    send(-7, 1'b0);
    drain();
    lat_en = 1'b0;
    check("midrst_recover", n_out - n0, 1);

    // Random traffic with random backpressure
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          x = rand_x();
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send(x, 1'($urandom_range(0, 1)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

`ifdef TANH_PWL_STATS_EN
    stat_clr = 1'b1;
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
    send(300000000, 1'b0);
    send(1000, 1'b0);
    send(-300000000, 1'b1);
    send(-5, 1'b1);
    send(240000001, 1'b0);
    drain();
    @(negedge clk);
    check("sat_count", sat_count, 3);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(300000000, 1'b0);
    begin
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    stat_clr  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
    @(negedge clk);
    check("sat_count_clr_wins", sat_count, 0);
    drain();
`endif

    check("final_queue_empty", exp_y.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
